// File: rtl/harris_nms.sv
// harris_nms: threshold + 3x3 non-max suppression on raster Harris scores, reporting (x,y,R) per corner; define HARRIS_NMS_COUNT_EN to add corner_count
module harris_nms #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int SCORE_W = 64,
  parameter int CRD_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] r_in,
  input  logic               r_valid,
  input  logic [SCORE_W-1:0] thresh,
  output logic               corner_valid,
  output logic [CRD_W-1:0]   corner_x,
  output logic [CRD_W-1:0]   corner_y,
  output logic [SCORE_W-1:0] corner_score,
`ifdef HARRIS_NMS_COUNT_EN
  output logic [2*CRD_W-1:0] corner_count,
`endif
  output logic               frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0] col, pcol;
  logic [RW-1:0] row, prow;
  logic [SCORE_W-1:0] lb0 [IMG_W];
  logic [SCORE_W-1:0] lb1 [IMG_W];
  logic signed [SCORE_W-1:0] win [3][3];
  logic signed [SCORE_W-1:0] thresh_q, ctr;
  logic pend, pend_last, hit, col_end, row_end;
  assign col_end = col == CW'(IMG_W-1);
  assign row_end = row == RW'(IMG_H-1);
  assign ctr = win[1][1];
  assign hit = pend && ctr > thresh_q &&
               ctr > win[0][0] && ctr > win[0][1] && ctr > win[0][2] && ctr > win[1][0] &&
               ctr >= win[1][2] && ctr >= win[2][0] && ctr >= win[2][1] && ctr >= win[2][2];
  always_ff @(posedge clk) begin
    if (!rst && r_valid) begin
      lb1[col] <= lb0[col];
      lb0[col] <= r_in;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      pcol <= '0;
      prow <= '0;
      pend <= 1'b0;
      pend_last <= 1'b0;
      thresh_q <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
      corner_valid <= 1'b0;
      corner_x <= '0;
      corner_y <= '0;
      corner_score <= '0;
      frame_done <= 1'b0;
    end else begin
      pend <= r_valid && col >= CW'(2) && row >= RW'(2);
      pend_last <= r_valid && col_end && row_end;
      corner_valid <= hit;
      frame_done <= pend_last;
      if (hit) begin
        corner_x <= CRD_W'(pcol);
        corner_y <= CRD_W'(prow);
        corner_score <= ctr;
      end
      if (r_valid) begin
        col <= col_end ? '0 : col + CW'(1);
        if (col_end) row <= row_end ? '0 : row + RW'(1);
        pcol <= col - CW'(1);
        prow <= row - RW'(1);
        if (col == '0 && row == '0) thresh_q <= thresh;
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb1[col];
        win[1][2] <= lb0[col];
        win[2][2] <= r_in;
      end
    end
  end
`ifdef HARRIS_NMS_COUNT_EN
  localparam int NW = 2*CRD_W;
  logic fresh;
  always_ff @(posedge clk) begin
    if (rst) begin
      corner_count <= '0;
      fresh <= 1'b1;
    end else begin
      if (hit) corner_count <= fresh ? NW'(1) : corner_count + NW'(1);
      if (pend_last) fresh <= 1'b1;
      else if (hit) fresh <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_harris_nms.sv
// tb_harris_nms: scoreboard bench for harris_nms on 8x8 frames against a whole-frame NMS reference model
module tb_harris_nms;
  localparam int W = 8, H = 8, SW = 64, CW = 16;
  logic clk = 1'b0, rst = 1'b1, r_valid = 1'b0;
  logic [SW-1:0] r_in = '0, thresh = '0, corner_score;
  logic [CW-1:0] corner_x, corner_y;
  logic corner_valid, frame_done;
`ifdef HARRIS_NMS_COUNT_EN
  logic [2*CW-1:0] corner_count;
`endif
  typedef struct {int x; int y; longint s; int due;} exp_t;
  typedef struct {int due; int cnt;} fd_t;
  exp_t exp_q[$];
  fd_t fd_q[$];
  longint img [H][W];
  bit cmap [H][W];
  int edges = 0, checks = 0, errors = 0, ncorner = 0;
  harris_nms #(.IMG_W(W), .IMG_H(H), .SCORE_W(SW), .CRD_W(CW)) dut (
    .clk(clk), .rst(rst), .r_in(r_in), .r_valid(r_valid), .thresh(thresh),
    .corner_valid(corner_valid), .corner_x(corner_x), .corner_y(corner_y),
    .corner_score(corner_score),
`ifdef HARRIS_NMS_COUNT_EN
    .corner_count(corner_count),
`endif
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;
  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (edge %0d)", n, a, e, edges);
    end
  endtask
  always @(negedge clk) begin
    if (corner_valid) begin
      if (exp_q.size() == 0) chk("unexpected corner_valid", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("corner_x", longint'(corner_x), e.x);
        chk("corner_y", longint'(corner_y), e.y);
        chk("corner_score", $signed(corner_score), e.s);
        chk("corner edge", edges, e.due);
      end
    end
    if (frame_done) begin
      if (fd_q.size() == 0) chk("unexpected frame_done", 1, 0);
      else begin
        fd_t f;
        f = fd_q.pop_front();
        chk("frame_done edge", edges, f.due);
`ifdef HARRIS_NMS_COUNT_EN
        chk("corner_count", longint'(corner_count), f.cnt);
`endif
      end
    end
  end
  task automatic fill(input longint v);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = v;
  endtask
  task automatic model(input longint th);
    ncorner = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        cmap[y][x] = 1'b0;
    for (int y = 1; y < H-1; y++)
      for (int x = 1; x < W-1; x++) begin
        bit ok;
        longint c;
        c = img[y][x];
        ok = c > th;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy != 0 || dx != 0) begin
              longint n;
              n = img[y+dy][x+dx];
              if (dy < 0 || (dy == 0 && dx < 0)) ok = ok && (c > n);
              else ok = ok && (c >= n);
            end
        cmap[y][x] = ok;
        ncorner += int'(ok);
      end
  endtask
  task automatic purge(input int d);
    for (int i = exp_q.size()-1; i >= 0; i--)
      if (exp_q[i].due == d) exp_q.delete(i);
    for (int i = fd_q.size()-1; i >= 0; i--)
      if (fd_q[i].due == d) fd_q.delete(i);
  endtask
  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
    chk("missing corners", exp_q.size(), 0);
    chk("missing frame_done", fd_q.size(), 0);
  endtask
  task automatic run_frame(input longint th, input int gap, input int ax, input int ay);
    model(th);
    thresh = th;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (x == ax && y == ay) begin
          rst = 1'b1;
          r_valid = 1'b1;
          r_in = img[y][x];
          purge(edges + 1);
          @(posedge clk);
          #1;
          rst = 1'b0;
          r_valid = 1'b0;
          chk("abort corner_valid", corner_valid, 0);
          chk("abort frame_done", frame_done, 0);
          return;
        end
        while ($urandom_range(99) < gap) begin
          r_valid = 1'b0;
          r_in = {$urandom, $urandom};
          @(posedge clk);
          #1;
        end
        r_valid = 1'b1;
        r_in = img[y][x];
        @(posedge clk);
        #1;
        if (x == 0 && y == 0) thresh = {$urandom, $urandom};
        if (x >= 2 && y >= 2 && cmap[y-1][x-1]) exp_q.push_back('{x-1, y-1, img[y-1][x-1], edges+1});
        if (x == W-1 && y == H-1) fd_q.push_back('{edges+1, ncorner});
      end
    r_valid = 1'b0;
    drain();
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    r_valid = 1'b1;
    repeat (3) begin
      r_in = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    chk("reset corner_valid", corner_valid, 0);
    chk("reset corner_x", longint'(corner_x), 0);
    chk("reset corner_y", longint'(corner_y), 0);
    chk("reset corner_score", $signed(corner_score), 0);
    chk("reset frame_done", frame_done, 0);
    rst = 1'b0;
    r_valid = 1'b0;
    fill(0); img[4][3] = 1000;
    run_frame(10, 0, -1, -1);
    fill(0); img[3][3] = 500; img[3][4] = 500;
    run_frame(10, 0, -1, -1);
    fill(0); img[4][4] = 5;
    run_frame(10, 0, -1, -1);
    fill(0); img[2][0] = 1000; img[5][7] = 1000; img[0][2] = 1000; img[7][6] = 1000;
    run_frame(10, 0, -1, -1);
    fill(0); img[6][6] = 1000;
    run_frame(10, 0, -1, -1);
    fill(0); img[4][3] = 1000;
    run_frame(10, 40, -1, -1);
    fill(0); img[1][2] = 700; img[3][3] = 900;
    run_frame(10, 0, 5, 4);
    fill(0); img[2][5] = 800;
    run_frame(10, 0, -1, -1);
    fill(-100); img[4][4] = -50;
    run_frame(-60, 0, -1, -1);
    fill(0); img[2][2] = 300; img[2][5] = 300; img[5][3] = 300;
    run_frame(10, 10, -1, -1);
    repeat (3) begin
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          img[y][x] = longint'($urandom_range(7)) - 3;
      run_frame(longint'($urandom_range(4)) - 2, 20, -1, -1);
    end
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = longint'({$urandom, $urandom});
    run_frame(0, 0, -1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
